multicycle_ctrl: RTL and testbench

- Control unit for the multicycle CPU. It sequences the shared ALU, register file, instruction/data memories and PC through the IF/ID/EXE/MEM/WB states.
- Each state is driven from the latched opcode and the ALU zero/sign flags.
- The block owns the state register and a retired-instruction counter. All datapath enables and mux selects are decoded from (state, opcode, flags).

---
 rtl/multicycle_ctrl_pkg.sv | 79 +++++++
 rtl/multicycle_ctrl_decode.sv | 120 ++++++++++++
 rtl/multicycle_ctrl.sv | 120 ++++++++++++
 tb/tb_multicycle_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle CPU control unit: state encodings,
// opcodes, ALU operation codes (also used by the ALU), PC source and
// register-destination selects, plus small opcode classification helpers.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IF     = 3'b000,
        ST_ID     = 3'b001,
        ST_EXE_LS = 3'b010,
        ST_MEM    = 3'b011,
        ST_WB_LD  = 3'b100,
        ST_EXE_BR = 3'b101,
        ST_EXE_AL = 3'b110,
        ST_WB_AL  = 3'b111
    } state_t;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_ADDIU = 6'b000010;
    localparam logic [5:0] OP_AND   = 6'b010000;
    localparam logic [5:0] OP_ANDI  = 6'b010001;
    localparam logic [5:0] OP_ORI   = 6'b010010;
    localparam logic [5:0] OP_XORI  = 6'b010011;
    localparam logic [5:0] OP_SLL   = 6'b011000;
    localparam logic [5:0] OP_SLT   = 6'b100110;
    localparam logic [5:0] OP_SLTI  = 6'b100111;
    localparam logic [5:0] OP_SW    = 6'b110000;
    localparam logic [5:0] OP_LW    = 6'b110001;
    localparam logic [5:0] OP_BEQ   = 6'b110100;
    localparam logic [5:0] OP_BNE   = 6'b110101;
    localparam logic [5:0] OP_BLTZ  = 6'b110110;
    localparam logic [5:0] OP_J     = 6'b111000;
    localparam logic [5:0] OP_JR    = 6'b111001;
    localparam logic [5:0] OP_JAL   = 6'b111010;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_SLTU = 3'b010;
    localparam logic [2:0] ALU_SLT  = 3'b011;
    localparam logic [2:0] ALU_SLL  = 3'b100;
    localparam logic [2:0] ALU_OR   = 3'b101;
    localparam logic [2:0] ALU_AND  = 3'b110;
    localparam logic [2:0] ALU_XOR  = 3'b111;

    localparam logic [1:0] PC_NEXT   = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_RS     = 2'b10;
    localparam logic [1:0] PC_JUMP   = 2'b11;

    localparam logic [1:0] RD_RA = 2'b00;
    localparam logic [1:0] RD_RT = 2'b01;
    localparam logic [1:0] RD_RD = 2'b10;

    function automatic logic is_alu_op(input logic [5:0] op);
        return op inside {OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ANDI, OP_ORI,
                          OP_XORI, OP_SLL, OP_SLT, OP_SLTI};
    endfunction

    function automatic logic is_imm_op(input logic [5:0] op);
        return op inside {OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI};
    endfunction

    function automatic logic [2:0] alu_op_of(input logic [5:0] op);
        logic [2:0] v;
        v = ALU_ADD;
        case (op)
            OP_SUB:           v = ALU_SUB;
            OP_AND, OP_ANDI:  v = ALU_AND;
            OP_ORI:           v = ALU_OR;
            OP_XORI:          v = ALU_XOR;
            OP_SLL:           v = ALU_SLL;
            OP_SLT, OP_SLTI:  v = ALU_SLT;
            default:          v = ALU_ADD;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// ctrl_decode: combinational control decode for the multicycle CPU.
// Inputs : i_state, i_opcode, i_zero, i_sign, i_en (0 forces all outputs low)
// Outputs: datapath enables and mux selects (o_pcwre ... o_pcsrc)
module ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  state_t      i_state,
    input  logic [5:0]  i_opcode,
    input  logic        i_zero,
    input  logic        i_sign,
    input  logic        i_en,
    output logic        o_pcwre,
    output logic        o_irwre,
    output logic        o_insmemrw,
    output logic        o_alusrca,
    output logic        o_alusrcb,
    output logic        o_extsel,
    output logic [2:0]  o_aluop,
    output logic        o_mrd,
    output logic        o_mwr,
    output logic        o_dbdatasrc,
    output logic        o_regwre,
    output logic [1:0]  o_regdst,
    output logic        o_wrregdsrc,
    output logic [1:0]  o_pcsrc
);

    logic w_taken;

    always_comb begin
        w_taken = ((i_opcode == OP_BEQ)  &&  i_zero) ||
                  ((i_opcode == OP_BNE)  && !i_zero) ||
                  ((i_opcode == OP_BLTZ) &&  i_sign);
    end

    always_comb begin
        o_pcwre     = 1'b0;
        o_irwre     = 1'b0;
        o_insmemrw  = 1'b0;
        o_alusrca   = 1'b0;
        o_alusrcb   = 1'b0;
        o_extsel    = 1'b0;
        o_aluop     = ALU_ADD;
        o_mrd       = 1'b0;
        o_mwr       = 1'b0;
        o_dbdatasrc = 1'b0;
        o_regwre    = 1'b0;
        o_regdst    = RD_RA;
        o_wrregdsrc = 1'b0;
        o_pcsrc     = PC_NEXT;
        if (i_en) begin
            case (i_state)
                ST_IF: begin
                    o_insmemrw = 1'b1;
                    o_irwre    = 1'b1;
                end
                ST_ID: begin
                    case (i_opcode)
                        OP_J: begin
                            o_pcwre = 1'b1;
                            o_pcsrc = PC_JUMP;
                        end
                        OP_JR: begin
                            o_pcwre = 1'b1;
                            o_pcsrc = PC_RS;
                        end
                        OP_JAL: begin
                            o_pcwre  = 1'b1;
                            o_pcsrc  = PC_JUMP;
                            o_regwre = 1'b1;
                            o_regdst = RD_RA;
                        end
                        OP_HALT, OP_BEQ, OP_BNE, OP_BLTZ, OP_SW, OP_LW: ;
                        default: begin
                            // Unknown opcodes retire here as a NOP.
                            o_pcwre = !is_alu_op(i_opcode);
                        end
                    endcase
                end
                ST_EXE_AL, ST_WB_AL: begin
                    o_aluop   = alu_op_of(i_opcode);
                    o_alusrca = (i_opcode == OP_SLL);
                    o_alusrcb = is_imm_op(i_opcode);
                    o_extsel  = !(i_opcode inside {OP_ANDI, OP_ORI, OP_XORI});
                    if (i_state == ST_WB_AL) begin
                        o_regwre    = 1'b1;
                        o_regdst    = is_imm_op(i_opcode) ? RD_RT : RD_RD;
                        o_wrregdsrc = 1'b1;
                        o_pcwre     = 1'b1;
                    end
                end
                ST_EXE_BR: begin
                    o_aluop = ALU_SUB;
                    o_pcwre = 1'b1;
                    o_pcsrc = w_taken ? PC_BRANCH : PC_NEXT;
                end
                ST_EXE_LS, ST_MEM: begin
                    o_aluop   = ALU_ADD;
                    o_alusrcb = 1'b1;
                    o_extsel  = 1'b1;
                    if (i_state == ST_MEM) begin
                        o_mwr   = (i_opcode == OP_SW);
                        o_pcwre = (i_opcode == OP_SW);
                        o_mrd   = (i_opcode == OP_LW);
                    end
                end
                ST_WB_LD: begin
                    o_mrd       = 1'b1;
                    o_dbdatasrc = 1'b1;
                    o_regwre    = 1'b1;
                    o_regdst    = RD_RT;
                    o_wrregdsrc = 1'b1;
                    o_pcwre     = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control unit of the multicycle CPU. Holds the state
// register, the halted flag and the retired-instruction counter; control
// outputs come from ctrl_decode.
// Inputs : CLK, RST (sync, active-low), opcode, zero, sign
// Outputs: PCWre, IRWre, InsMemRW, ALUSrcA/B, ExtSel, ALUOp, mRD, mWR,
//          DBDataSrc, RegWre, RegDst, WrRegDSrc, PCSrc, state, instret
//
// state     | meaning
// IF  000   | fetch, load IR
// ID  001   | decode; jumps/NOP retire here; halt parks here
// EXE_LS 010| address calc for lw/sw
// MEM 011   | data memory access (sw retires)
// WB_LD 100 | load write-back
// EXE_BR 101| compare and branch
// EXE_AL 110| ALU execute
// WB_AL 111 | ALU write-back
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             sign,
    output logic             PCWre,
    output logic             IRWre,
    output logic             InsMemRW,
    output logic             ALUSrcA,
    output logic             ALUSrcB,
    output logic             ExtSel,
    output logic [2:0]       ALUOp,
    output logic             mRD,
    output logic             mWR,
    output logic             DBDataSrc,
    output logic             RegWre,
    output logic [1:0]       RegDst,
    output logic             WrRegDSrc,
    output logic [1:0]       PCSrc,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret
);

    state_t           r_state;
    state_t           w_next_state;
    logic             r_halted;
    logic             w_next_halted;
    logic [CNT_W-1:0] r_instret;
    logic             w_dec_en;

    // While RST is low every output reads zero, even before the reset edge.
    assign w_dec_en = RST && !r_halted;
    assign state    = RST ? r_state : ST_IF;
    assign instret  = RST ? r_instret : '0;

    ctrl_decode u_decode (
        .i_state     (r_state),
        .i_opcode    (opcode),
        .i_zero      (zero),
        .i_sign      (sign),
        .i_en        (w_dec_en),
        .o_pcwre     (PCWre),
        .o_irwre     (IRWre),
        .o_insmemrw  (InsMemRW),
        .o_alusrca   (ALUSrcA),
        .o_alusrcb   (ALUSrcB),
        .o_extsel    (ExtSel),
        .o_aluop     (ALUOp),
        .o_mrd       (mRD),
        .o_mwr       (mWR),
        .o_dbdatasrc (DBDataSrc),
        .o_regwre    (RegWre),
        .o_regdst    (RegDst),
        .o_wrregdsrc (WrRegDSrc),
        .o_pcsrc     (PCSrc)
    );

    always_comb begin
        w_next_state  = r_state;
        w_next_halted = r_halted;
        case (r_state)
            ST_IF: w_next_state = ST_ID;
            ST_ID: begin
                if (!r_halted) begin
                    case (opcode)
                        OP_J, OP_JR, OP_JAL:    w_next_state = ST_IF;
                        OP_HALT:                w_next_halted = 1'b1;
                        OP_BEQ, OP_BNE, OP_BLTZ: w_next_state = ST_EXE_BR;
                        OP_LW, OP_SW:           w_next_state = ST_EXE_LS;
                        default: w_next_state = is_alu_op(opcode) ? ST_EXE_AL : ST_IF;
                    endcase
                end
            end
            ST_EXE_AL: w_next_state = ST_WB_AL;
            ST_WB_AL:  w_next_state = ST_IF;
            ST_EXE_BR: w_next_state = ST_IF;
            ST_EXE_LS: w_next_state = ST_MEM;
            ST_MEM:    w_next_state = (opcode == OP_LW) ? ST_WB_LD : ST_IF;
            ST_WB_LD:  w_next_state = ST_IF;
            default:   w_next_state = ST_IF;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state   <= ST_IF;
            r_halted  <= 1'b0;
            r_instret <= '0;
        end else begin
            r_state  <= w_next_state;
            r_halted <= w_next_halted;
            // PCWre marks the final cycle of every instruction.
            if (PCWre) begin
                r_instret <= r_instret + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    localparam int TB_CNT_W = 4;
    localparam int CNT_MOD  = 16;

    localparam logic [5:0] C_ADD = 6'b000000, C_SUB = 6'b000001, C_ADDIU = 6'b000010;
    localparam logic [5:0] C_AND = 6'b010000, C_ANDI = 6'b010001, C_ORI = 6'b010010;
    localparam logic [5:0] C_XORI = 6'b010011, C_SLL = 6'b011000, C_SLT = 6'b100110;
    localparam logic [5:0] C_SLTI = 6'b100111, C_SW = 6'b110000, C_LW = 6'b110001;
    localparam logic [5:0] C_BEQ = 6'b110100, C_BNE = 6'b110101, C_BLTZ = 6'b110110;
    localparam logic [5:0] C_J = 6'b111000, C_JR = 6'b111001, C_JAL = 6'b111010;
    localparam logic [5:0] C_HALT = 6'b111111, C_NOP = 6'b001111;

    localparam int CL_NOP = 0, CL_J = 1, CL_BR = 2, CL_SW = 3, CL_LW = 4, CL_AL = 5, CL_HALT = 6;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic [5:0] opcode = 6'b0;
    logic zero = 1'b0;
    logic sign = 1'b0;
    logic PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ExtSel, mRD, mWR;
    logic DBDataSrc, RegWre, WrRegDSrc;
    logic [2:0] ALUOp, state;
    logic [1:0] RegDst, PCSrc;
    logic [TB_CNT_W-1:0] instret;

    int n_checks = 0;
    int n_fail = 0;

    multicycle_ctrl #(.CNT_W(TB_CNT_W)) dut (
        .CLK(CLK), .RST(RST), .opcode(opcode), .zero(zero), .sign(sign),
        .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ExtSel(ExtSel), .ALUOp(ALUOp), .mRD(mRD), .mWR(mWR),
        .DBDataSrc(DBDataSrc), .RegWre(RegWre), .RegDst(RegDst),
        .WrRegDSrc(WrRegDSrc), .PCSrc(PCSrc), .state(state), .instret(instret)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int cls(input logic [5:0] op);
        case (op)
            C_J, C_JR, C_JAL:                       return CL_J;
            C_BEQ, C_BNE, C_BLTZ:                   return CL_BR;
            C_SW:                                   return CL_SW;
            C_LW:                                   return CL_LW;
            C_HALT:                                 return CL_HALT;
            C_ADD, C_SUB, C_ADDIU, C_AND, C_ANDI, C_ORI,
            C_XORI, C_SLL, C_SLT, C_SLTI:           return CL_AL;
            default:                                return CL_NOP;
        endcase
    endfunction

    // Index of the final (retiring) cycle of an instruction, counting IF as 0.
    function automatic int last_ph(input int c);
        case (c)
            CL_J, CL_NOP: return 1;
            CL_BR:        return 2;
            CL_SW, CL_AL: return 3;
            CL_LW:        return 4;
            default:      return 1000;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] op);
        case (op)
            C_SUB:          return 3'b001;
            C_AND, C_ANDI:  return 3'b110;
            C_ORI:          return 3'b101;
            C_XORI:         return 3'b111;
            C_SLL:          return 3'b100;
            C_SLT, C_SLTI:  return 3'b011;
            default:        return 3'b000;
        endcase
    endfunction

    // Expected {PCWre,IRWre,InsMemRW,ALUSrcA,ALUSrcB,ExtSel,ALUOp,mRD,mWR,
    //           DBDataSrc,RegWre,RegDst,WrRegDSrc,PCSrc,state}
    function automatic logic [20:0] exp_ctrl(input logic [5:0] op, input int ph,
                                             input bit halted, input logic z, input logic s);
        logic pcw, irw, ins, sa, sb, ext, mrd, mwr, dbs, rw, wrs, imm;
        logic [2:0] aop, st;
        logic [1:0] rd, pcs;
        int c;
        {pcw, irw, ins, sa, sb, ext, mrd, mwr, dbs, rw, wrs} = '0;
        aop = 0; st = 0; rd = 0; pcs = 0;
        c = cls(op);
        imm = op inside {C_ADDIU, C_ANDI, C_ORI, C_XORI, C_SLTI};
        if (halted) begin
            st = 3'd1;
        end else if (ph == 0) begin
            ins = 1; irw = 1;
        end else if (ph == 1) begin
            st = 3'd1;
            if (c == CL_J) begin
                pcw = 1;
                pcs = (op == C_JR) ? 2'd2 : 2'd3;
                if (op == C_JAL) rw = 1;
            end else if (c == CL_NOP) begin
                pcw = 1;
            end
        end else if (c == CL_AL) begin
            st = (ph == 2) ? 3'd6 : 3'd7;
            aop = alu_of(op);
            sa = (op == C_SLL);
            sb = imm;
            ext = !(op inside {C_ANDI, C_ORI, C_XORI});
            if (ph == 3) begin
                rw = 1; rd = imm ? 2'd1 : 2'd2; wrs = 1; pcw = 1;
            end
        end else if (c == CL_BR) begin
            st = 3'd5; aop = 3'd1; pcw = 1;
            pcs = ((op == C_BEQ && z) || (op == C_BNE && !z) || (op == C_BLTZ && s)) ? 2'd1 : 2'd0;
        end else if (ph == 4) begin
            st = 3'd4; mrd = 1; dbs = 1; rw = 1; rd = 2'd1; wrs = 1; pcw = 1;
        end else begin
            st = (ph == 2) ? 3'd2 : 3'd3;
            sb = 1; ext = 1;
            if (ph == 3) begin
                if (c == CL_SW) begin mwr = 1; pcw = 1; end
                else mrd = 1;
            end
        end
        return {pcw, irw, ins, sa, sb, ext, aop, mrd, mwr, dbs, rw, rd, wrs, pcs, st};
    endfunction

    // Instruction-level model: phase within the current instruction.
    int m_ph = 0;
    bit m_halt = 0;
    int m_ret = 0;
    bit m_live = 0;

    always @(posedge CLK) begin
        if (!RST) begin
            m_ph = 0; m_halt = 0; m_ret = 0; m_live = 1;
        end else if (m_live && !m_halt) begin
            if (m_ph == 1 && cls(opcode) == CL_HALT) m_halt = 1;
            else if (m_ph == last_ph(cls(opcode))) begin
                m_ret = (m_ret + 1) % CNT_MOD;
                m_ph = 0;
            end else m_ph++;
        end
    end

    always @(negedge CLK) begin
        logic [20:0] dut_v, exp_v;
        if (m_live) begin
            dut_v = {PCWre, IRWre, InsMemRW, ALUSrcA, ALUSrcB, ExtSel, ALUOp, mRD, mWR,
                     DBDataSrc, RegWre, RegDst, WrRegDSrc, PCSrc, state};
            exp_v = RST ? exp_ctrl(opcode, m_ph, m_halt, zero, sign) : 21'd0;
            check("ctrl_vec", dut_v, exp_v);
            check("instret", instret, RST ? m_ret : 0);
        end
    end

    task automatic do_reset(input int n);
        RST = 1'b0;
        #1;
        check("rst_state", state, 0);
        check("rst_pcwre_irwre", {PCWre, IRWre, InsMemRW}, 0);
        repeat (n) @(posedge CLK);
        #1 RST = 1'b1;
        #1;
        check("post_rst_state", state, 0);
        check("post_rst_fetch", {IRWre, InsMemRW}, 2'b11);
        check("post_rst_instret", instret, 0);
    endtask

    // Runs one instruction starting from IF; records the state trail as octal digits.
    task automatic run_instr(input logic [5:0] op, input logic z, input logic s,
                             input int ncyc, input string nm, input logic [23:0] exp_hist,
                             input logic [1:0] exp_pcsrc, input int exp_pcw);
        logic [23:0] hist;
        logic [1:0] last_pcsrc;
        int pcw;
        opcode = op; zero = z; sign = s;
        hist = 0; pcw = 0; last_pcsrc = 0;
        for (int i = 0; i < ncyc; i++) begin
            #2;
            hist = {hist[20:0], state};
            if (PCWre) begin
                pcw++;
                last_pcsrc = PCSrc;
            end
            @(posedge CLK);
            #1;
        end
        check({nm, "_states"}, hist, exp_hist);
        check({nm, "_pcwre_cnt"}, pcw, exp_pcw);
        if (exp_pcw > 0) check({nm, "_pcsrc"}, last_pcsrc, exp_pcsrc);
    endtask

    initial begin
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b1;
        // Reset in the middle of an ALU instruction.
        opcode = C_ADD;
        repeat (2) @(posedge CLK);
        #2;
        check("mid_add_state", state, 6);
        do_reset(2);

        run_instr(C_ADD,   0, 0, 4, "add",   24'o00000167, 2'd0, 1);
        check("instret_after_add", instret, 1);
        run_instr(C_SUB,   0, 0, 4, "sub",   24'o00000167, 2'd0, 1);
        run_instr(C_ADDIU, 0, 0, 4, "addiu", 24'o00000167, 2'd0, 1);
        run_instr(C_AND,   0, 0, 4, "and",   24'o00000167, 2'd0, 1);
        run_instr(C_ANDI,  0, 0, 4, "andi",  24'o00000167, 2'd0, 1);
        run_instr(C_ORI,   0, 0, 4, "ori",   24'o00000167, 2'd0, 1);
        run_instr(C_XORI,  0, 0, 4, "xori",  24'o00000167, 2'd0, 1);
        run_instr(C_SLL,   0, 0, 4, "sll",   24'o00000167, 2'd0, 1);
        run_instr(C_SLT,   0, 0, 4, "slt",   24'o00000167, 2'd0, 1);
        run_instr(C_SLTI,  0, 0, 4, "slti",  24'o00000167, 2'd0, 1);
        run_instr(C_BEQ,   1, 0, 3, "beq_t", 24'o00000015, 2'd1, 1);
        run_instr(C_BEQ,   0, 0, 3, "beq_n", 24'o00000015, 2'd0, 1);
        run_instr(C_BNE,   0, 1, 3, "bne_t", 24'o00000015, 2'd1, 1);
        run_instr(C_BNE,   1, 0, 3, "bne_n", 24'o00000015, 2'd0, 1);
        run_instr(C_BLTZ,  0, 1, 3, "bltz_t", 24'o00000015, 2'd1, 1);
        run_instr(C_BLTZ,  1, 0, 3, "bltz_n", 24'o00000015, 2'd0, 1);
        run_instr(C_LW,    0, 0, 5, "lw",    24'o00001234, 2'd0, 1);
        run_instr(C_SW,    0, 0, 4, "sw",    24'o00000123, 2'd0, 1);
        run_instr(C_JAL,   0, 0, 2, "jal",   24'o00000001, 2'd3, 1);
        run_instr(C_J,     0, 0, 2, "j",     24'o00000001, 2'd3, 1);
        run_instr(C_JR,    0, 0, 2, "jr",    24'o00000001, 2'd2, 1);
        run_instr(C_NOP,   0, 0, 2, "nop",   24'o00000001, 2'd0, 1);
        check("instret_after_22", instret, 6);

        // Counter wrap at 2^CNT_W-1 -> 0.
        do_reset(1);
        for (int i = 0; i < 15; i++)
            run_instr(C_NOP, 0, 0, 2, "nopw", 24'o00000001, 2'd0, 1);
        check("instret_15", instret, 15);
        run_instr(C_NOP, 0, 0, 2, "nopw", 24'o00000001, 2'd0, 1);
        check("instret_wrap", instret, 0);

        // Halt parks in ID, never retires; reset recovers.
        run_instr(C_HALT, 0, 0, 22, "halt", 24'o11111111, 2'd0, 0);
        check("halt_state", state, 1);
        check("halt_instret", instret, 0);
        do_reset(1);
        run_instr(C_ADD, 0, 0, 4, "add_after_halt", 24'o00000167, 2'd0, 1);
        check("instret_after_recover", instret, 1);

        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
